// File: rtl/comporta_servo_pwm_pkg.sv
// Shared constants and state encoding for the gate servo PWM driver.
// The gate control unit and top level import the same definitions.
package comporta_servo_pwm_pkg;

   typedef enum logic [3:0] {
      DESLIGADO = 4'b0000,
      ALTO      = 4'b0001,
      BAIXO     = 4'b0010
   } estado_t;

   localparam logic [3:0] DB_ESTADO_INVALIDO = 4'b1111;

   localparam int N_PADRAO             = 3;
   localparam int PERIODO_PADRAO       = 1_000_000;
   localparam int LARGURA_MIN_PADRAO   = 50_000;
   localparam int LARGURA_PASSO_PADRAO = 7_143;

endpackage

// File: rtl/comporta_servo_pwm_if.sv
// Position in, PWM and debug/status out, between the gate datapath and the servo driver.
interface comporta_servo_pwm_if
   import comporta_servo_pwm_pkg::*;
#(
   parameter int N = N_PADRAO
);
   logic         ligar;
   logic [N-1:0] posicao;
   logic         pwm;
   logic [N-1:0] dbPosicao;
   logic         fimPeriodo;
   logic         aplicado;
   logic [3:0]   dbEstado;

   modport master (
      output ligar, posicao,
      input  pwm, dbPosicao, fimPeriodo, aplicado, dbEstado
   );

   modport slave (
      input  ligar, posicao,
      output pwm, dbPosicao, fimPeriodo, aplicado, dbEstado
   );
endinterface

// File: rtl/comporta_servo_pwm_contador_periodo.sv
// Modulo-PERIODO cycle counter; fim flags the last cycle of the period.
module contador_periodo #(
   parameter int PERIODO = 20,
   parameter int CW      = 5
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          zera,
   input  logic          conta,
   output logic [CW-1:0] cnt,
   output logic          fim
);
   localparam logic [CW-1:0] ULTIMO = CW'(PERIODO - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_ff @(posedge clock) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (zera) begin
         cnt_d = '0;
      end else if (conta) begin
         cnt_d = (cnt_q == ULTIMO) ? '0 : cnt_q + CW'(1);
      end
   end

   assign cnt = cnt_q;
   assign fim = (cnt_q == ULTIMO);
endmodule

// File: rtl/comporta_servo_pwm.sv
// Servo PWM driver: latches the gate position only at period boundaries so
// the pulse is never glitched, and exposes debug/status pulses.
module comporta_servo_pwm
   import comporta_servo_pwm_pkg::*;
#(
   parameter int N             = N_PADRAO,
   parameter int PERIODO       = PERIODO_PADRAO,
   parameter int LARGURA_MIN   = LARGURA_MIN_PADRAO,
   parameter int LARGURA_PASSO = LARGURA_PASSO_PADRAO
) (
   input  logic                clock,
   input  logic                reset,
   comporta_servo_pwm_if.slave bus
);
   localparam int CW = (PERIODO > 1) ? $clog2(PERIODO) : 1;
   localparam longint LARGURA_MAX = longint'(LARGURA_MIN)
                                  + ((longint'(1) << N) - 1) * longint'(LARGURA_PASSO);
   localparam logic [CW-1:0] L_MIN   = CW'(LARGURA_MIN);
   localparam logic [CW-1:0] L_PASSO = CW'(LARGURA_PASSO);

   if (LARGURA_MIN < 1 || LARGURA_MAX >= longint'(PERIODO)) begin : g_param_invalido
      $error("comporta_servo_pwm: widest pulse must fit inside PERIODO and LARGURA_MIN >= 1");
   end

   estado_t       state_q, state_d;
   logic [CW-1:0] largura_q, largura_d;
   logic [N-1:0]  db_posicao_q, db_posicao_d;
   logic          pwm_q, pwm_d;
   logic          fim_periodo_q, fim_periodo_d;
   logic          aplicado_q, aplicado_d;
   logic [3:0]    db_estado;
   logic          latch;
   logic          zera, conta, fim;
   logic [CW-1:0] cnt;

   contador_periodo #(
      .PERIODO (PERIODO),
      .CW      (CW)
   ) u_contador (
      .clock (clock),
      .reset (reset),
      .zera  (zera),
      .conta (conta),
      .cnt   (cnt),
      .fim   (fim)
   );

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q       <= DESLIGADO;
         largura_q     <= L_MIN;
         db_posicao_q  <= '0;
         pwm_q         <= 1'b0;
         fim_periodo_q <= 1'b0;
         aplicado_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         largura_q     <= largura_d;
         db_posicao_q  <= db_posicao_d;
         pwm_q         <= pwm_d;
         fim_periodo_q <= fim_periodo_d;
         aplicado_q    <= aplicado_d;
      end
   end

   // Position and pulse width only change on a latch, so a period is never altered midway.
   always_comb begin
      state_d      = state_q;
      latch        = 1'b0;
      largura_d    = largura_q;
      db_posicao_d = db_posicao_q;
      case (state_q)
         DESLIGADO: begin
            if (bus.ligar) begin
               latch   = 1'b1;
               state_d = ALTO;
            end
         end
         ALTO: begin
            if (cnt == largura_q - CW'(1)) begin
               state_d = BAIXO;
            end
         end
         BAIXO: begin
            if (fim) begin
               latch   = bus.ligar;
               state_d = bus.ligar ? ALTO : DESLIGADO;
            end
         end
         default: state_d = DESLIGADO;
      endcase
      if (latch) begin
         db_posicao_d = bus.posicao;
         largura_d    = L_MIN + CW'(bus.posicao) * L_PASSO;
      end
   end

   always_comb begin
      conta         = (state_q == ALTO) || (state_q == BAIXO);
      zera          = !conta || ((state_q == BAIXO) && fim);
      pwm_d         = (state_q == ALTO);
      fim_periodo_d = (state_q == BAIXO) && fim;
      aplicado_d    = latch && ((state_q == DESLIGADO) || (bus.posicao != db_posicao_q));
      case (state_q)
         DESLIGADO, ALTO, BAIXO: db_estado = state_q;
         default:                db_estado = DB_ESTADO_INVALIDO;
      endcase
   end

   assign bus.pwm        = pwm_q;
   assign bus.dbPosicao  = db_posicao_q;
   assign bus.fimPeriodo = fim_periodo_q;
   assign bus.aplicado   = aplicado_q;
   assign bus.dbEstado   = db_estado;
endmodule

// File: tb/tb_comporta_servo_pwm.sv
// Self-checking bench for comporta_servo_pwm against a period-level timing model.
module tb_comporta_servo_pwm;
   localparam int N     = 3;
   localparam int PER   = 20;
   localparam int LMIN  = 4;
   localparam int PASSO = 2;

   logic         clock = 1'b0;
   logic         reset = 1'b0;
   logic         ligar = 1'b0;
   logic [N-1:0] posicao = '0;

   int n_cmp = 0;
   int n_err = 0;

   // Model: m_t counts edges since the last latch; pwm is high for edges 1..m_w after it.
   bit           m_on = 0;
   int           m_t = 0;
   int           m_w = LMIN;
   logic [N-1:0] m_pos = '0;
   logic         exp_pwm = 0, exp_fim = 0, exp_apl = 0;
   logic [3:0]   exp_estado = 4'd0;

   always #5 clock = ~clock;

   comporta_servo_pwm_if #(.N(N)) bus_if ();
   assign bus_if.ligar   = ligar;
   assign bus_if.posicao = posicao;

   comporta_servo_pwm #(
      .N(N), .PERIODO(PER), .LARGURA_MIN(LMIN), .LARGURA_PASSO(PASSO)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus_if)
   );

   task automatic tick();
      @(posedge clock);
      exp_fim = 0;
      exp_apl = 0;
      if (!reset) begin
         m_on = 0; m_t = 0; m_w = LMIN; m_pos = '0; exp_pwm = 0;
      end else if (!m_on) begin
         exp_pwm = 0;
         if (ligar) begin
            m_on = 1; m_t = 0; m_w = LMIN + int'(posicao) * PASSO;
            m_pos = posicao; exp_apl = 1;
         end
      end else begin
         m_t++;
         exp_pwm = (m_t <= m_w);
         if (m_t == PER) begin
            exp_fim = 1;
            if (ligar) begin
               exp_apl = (posicao != m_pos);
               m_pos = posicao; m_w = LMIN + int'(posicao) * PASSO; m_t = 0;
            end else begin
               m_on = 0;
            end
         end
      end
      exp_estado = !m_on ? 4'd0 : ((m_t < m_w) ? 4'd1 : 4'd2);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0; ligar = 1'b1; posicao = 3'd5;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++;
         if (bus_if.pwm !== 1'b0) begin
            n_err++; $display("FAIL reset_pwm cyc=%0d: got %b want 0", i, bus_if.pwm);
         end
         n_cmp++;
         if (bus_if.dbEstado !== 4'b0000) begin
            n_err++; $display("FAIL reset_estado cyc=%0d: got %b want 0000", i, bus_if.dbEstado);
         end
         n_cmp++;
         if (bus_if.dbPosicao !== 3'd0) begin
            n_err++; $display("FAIL reset_dbpos cyc=%0d: got %0d want 0", i, bus_if.dbPosicao);
         end
         n_cmp++;
         if ({bus_if.fimPeriodo, bus_if.aplicado} !== 2'b00) begin
            n_err++; $display("FAIL reset_pulses cyc=%0d: got %b want 00", i, {bus_if.fimPeriodo, bus_if.aplicado});
         end
      end
      $display("test_reset done");
   endtask

   task automatic test_steady();
      int hi = 0, nfim = 0, napl = 0;
      reset = 1'b1; ligar = 1'b1; posicao = 3'd0;
      for (int i = 1; i <= 61; i++) begin
         tick();
         hi += int'(bus_if.pwm); nfim += int'(bus_if.fimPeriodo); napl += int'(bus_if.aplicado);
         n_cmp++;
         if ({bus_if.pwm, bus_if.fimPeriodo, bus_if.aplicado} !== {exp_pwm, exp_fim, exp_apl}) begin
            n_err++; $display("FAIL steady_outs cyc=%0d: got %b want %b", i,
               {bus_if.pwm, bus_if.fimPeriodo, bus_if.aplicado}, {exp_pwm, exp_fim, exp_apl});
         end
      end
      n_cmp++;
      if (hi !== 12) begin n_err++; $display("FAIL steady_high_cycles: got %0d want 12", hi); end
      n_cmp++;
      if (nfim !== 3) begin n_err++; $display("FAIL steady_fim_count: got %0d want 3", nfim); end
      n_cmp++;
      if (napl !== 1) begin n_err++; $display("FAIL steady_aplicado_count: got %0d want 1", napl); end
      $display("test_steady done: high=%0d fim=%0d aplicado=%0d", hi, nfim, napl);
   endtask

   task automatic test_max_position();
      int hi = 0;
      do_reset();
      ligar = 1'b1; posicao = 3'd7;
      for (int i = 1; i <= 41; i++) begin
         tick();
         hi += int'(bus_if.pwm);
         n_cmp++;
         if ({bus_if.pwm, bus_if.dbEstado} !== {exp_pwm, exp_estado}) begin
            n_err++; $display("FAIL max_outs cyc=%0d: got %b want %b", i,
               {bus_if.pwm, bus_if.dbEstado}, {exp_pwm, exp_estado});
         end
      end
      n_cmp++;
      if (hi !== 36) begin n_err++; $display("FAIL max_high_cycles: got %0d want 36", hi); end
      n_cmp++;
      if (bus_if.dbPosicao !== 3'd7) begin n_err++; $display("FAIL max_dbpos: got %0d want 7", bus_if.dbPosicao); end
      $display("test_max_position done: high=%0d", hi);
   endtask

   task automatic test_mid_change();
      int hi1 = 0, hi2 = 0;
      do_reset();
      ligar = 1'b1; posicao = 3'd3;
      for (int i = 1; i <= 41; i++) begin
         tick();
         if (i == 3) posicao = 3'd5;
         if (i >= 2 && i <= 21) hi1 += int'(bus_if.pwm);
         if (i >= 22) hi2 += int'(bus_if.pwm);
         if (i == 21) begin
            n_cmp++;
            if (bus_if.aplicado !== 1'b1) begin n_err++; $display("FAIL mid_aplicado: got %b want 1", bus_if.aplicado); end
         end
         n_cmp++;
         if ({bus_if.pwm, bus_if.aplicado, bus_if.dbPosicao} !== {exp_pwm, exp_apl, m_pos}) begin
            n_err++; $display("FAIL mid_outs cyc=%0d: got %b want %b", i,
               {bus_if.pwm, bus_if.aplicado, bus_if.dbPosicao}, {exp_pwm, exp_apl, m_pos});
         end
      end
      n_cmp++;
      if (hi1 !== 10) begin n_err++; $display("FAIL mid_first_high: got %0d want 10", hi1); end
      n_cmp++;
      if (hi2 !== 14) begin n_err++; $display("FAIL mid_second_high: got %0d want 14", hi2); end
      $display("test_mid_change done: high=%0d then %0d", hi1, hi2);
   endtask

   task automatic test_drop_enable();
      int hi = 0;
      int w;
      do_reset();
      ligar = 1'b1; posicao = 3'($urandom_range(7));
      w = LMIN + int'(posicao) * PASSO;
      for (int i = 1; i <= 24; i++) begin
         tick();
         if (i == 2) ligar = 1'b0;
         if (i == 22) ligar = 1'b1;
         if (i >= 2 && i <= 21) hi += int'(bus_if.pwm);
         if (i == 22) begin
            n_cmp++;
            if ({bus_if.pwm, bus_if.dbEstado} !== 5'b0_0000) begin
               n_err++; $display("FAIL drop_idle: got %b want 0_0000", {bus_if.pwm, bus_if.dbEstado});
            end
         end
         if (i == 24) begin
            n_cmp++;
            if (bus_if.pwm !== 1'b1) begin n_err++; $display("FAIL drop_restart_pwm: got %b want 1", bus_if.pwm); end
         end
         n_cmp++;
         if ({bus_if.pwm, bus_if.fimPeriodo, bus_if.dbEstado} !== {exp_pwm, exp_fim, exp_estado}) begin
            n_err++; $display("FAIL drop_outs cyc=%0d: got %b want %b", i,
               {bus_if.pwm, bus_if.fimPeriodo, bus_if.dbEstado}, {exp_pwm, exp_fim, exp_estado});
         end
      end
      n_cmp++;
      if (hi !== w) begin n_err++; $display("FAIL drop_full_pulse: got %0d want %0d", hi, w); end
      $display("test_drop_enable done: posicao=%0d high=%0d", posicao, hi);
   endtask

   task automatic test_reset_mid_pulse();
      int hi = 0;
      int w;
      do_reset();
      ligar = 1'b1; posicao = 3'($urandom_range(7));
      w = LMIN + int'(posicao) * PASSO;
      for (int i = 1; i <= 25; i++) begin
         tick();
         if (i == 3) reset = 1'b0;
         if (i == 4) begin
            reset = 1'b1;
            n_cmp++;
            if ({bus_if.pwm, bus_if.dbEstado} !== 5'b0_0000) begin
               n_err++; $display("FAIL rstmid_cut: got %b want 0_0000", {bus_if.pwm, bus_if.dbEstado});
            end
         end
         if (i >= 6) hi += int'(bus_if.pwm);
         if (i == 25) begin
            n_cmp++;
            if (bus_if.fimPeriodo !== 1'b1) begin n_err++; $display("FAIL rstmid_fim: got %b want 1", bus_if.fimPeriodo); end
         end
         n_cmp++;
         if ({bus_if.pwm, bus_if.dbEstado} !== {exp_pwm, exp_estado}) begin
            n_err++; $display("FAIL rstmid_outs cyc=%0d: got %b want %b", i,
               {bus_if.pwm, bus_if.dbEstado}, {exp_pwm, exp_estado});
         end
      end
      n_cmp++;
      if (hi !== w) begin n_err++; $display("FAIL rstmid_restart_pulse: got %0d want %0d", hi, w); end
      $display("test_reset_mid_pulse done: posicao=%0d high=%0d", posicao, hi);
   endtask

   task automatic test_random();
      int errs0 = n_err;
      do_reset();
      ligar = 1'b1;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(7) == 0) posicao = 3'($urandom_range(7));
         if ($urandom_range(29) == 0) ligar = ~ligar;
         reset = ($urandom_range(149) != 0);
         tick();
         n_cmp++;
         if ({bus_if.pwm, bus_if.fimPeriodo, bus_if.aplicado, bus_if.dbPosicao, bus_if.dbEstado}
             !== {exp_pwm, exp_fim, exp_apl, m_pos, exp_estado}) begin
            n_err++; $display("FAIL random_outs cyc=%0d: got %b want %b", i,
               {bus_if.pwm, bus_if.fimPeriodo, bus_if.aplicado, bus_if.dbPosicao, bus_if.dbEstado},
               {exp_pwm, exp_fim, exp_apl, m_pos, exp_estado});
         end
      end
      $display("test_random done: %0d new errors", n_err - errs0);
   endtask

   initial begin
      test_reset();
      test_steady();
      test_max_position();
      test_mid_change();
      test_drop_enable();
      test_reset_mid_pulse();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
